// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester data-memory arbiter; define DMEM_ARBITER_RR_EN for round-robin grants
module dmem_arbiter #(
  parameter int RESP_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_req_valid,
  output logic        m0_req_ready,
  input  logic [31:0] m0_req_addr,
  input  logic [31:0] m0_req_wdata,
  input  logic [3:0]  m0_req_wmask,
  input  logic        m0_req_write,
  output logic        m0_resp_valid,
  input  logic        m0_resp_ready,
  output logic [31:0] m0_resp_rdata,
  input  logic        m1_req_valid,
  output logic        m1_req_ready,
  input  logic [31:0] m1_req_addr,
  input  logic [31:0] m1_req_wdata,
  input  logic [3:0]  m1_req_wmask,
  input  logic        m1_req_write,
  output logic        m1_resp_valid,
  input  logic        m1_resp_ready,
  output logic [31:0] m1_resp_rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wmask,
  output logic        mem_req_write,
  input  logic        mem_resp_valid,
  output logic        mem_resp_ready,
  input  logic [31:0] mem_resp_rdata,
  output logic        grant_id,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_e;

  // Counter value seen in the RESP cycle where the timeout is reached, and its saturation value.
  localparam logic [7:0] TO_LAST = 8'(RESP_TIMEOUT - 1);
  localparam logic [7:0] TO_MAX  = 8'(RESP_TIMEOUT);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;
  logic        write_q, write_d;
  logic        grant_q, grant_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        win_valid;
  logic        win_id;
  logic        rdy0, rdy1;
  logic        forced;
  logic        resp_v;
  logic        up_ready;
  logic [31:0] resp_rdata;

  assign win_valid = m0_req_valid | m1_req_valid;

`ifdef DMEM_ARBITER_RR_EN
  logic last_q, last_d;

  // Winner selection: under contention the requester not granted last time wins.
  always_comb begin
    win_id = ~m0_req_valid;
    if (m0_req_valid && m1_req_valid) win_id = ~last_q;
  end

  assign last_d = (state_q == ST_IDLE && win_valid) ? win_id : last_q;

  // Last-grant register, reset so that m0 wins the first contended grant.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) last_q <= 1'b1;
    else         last_q <= last_d;
  end
`else
  // Fixed priority: m0 wins whenever it is requesting.
  assign win_id = ~m0_req_valid;
`endif

  assign up_ready = grant_q ? m1_resp_ready : m0_resp_ready;
  // A forced completion stands in only while the memory has not answered.
  assign forced   = (state_q == ST_RESP) && !mem_resp_valid && (cnt_q >= TO_LAST);

  // Next-state and output decode for the IDLE/REQ/RESP sequence.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    wmask_d        = wmask_q;
    write_d        = write_q;
    grant_d        = grant_q;
    cnt_d          = cnt_q;
    rdy0           = 1'b0;
    rdy1           = 1'b0;
    mem_req_valid  = 1'b0;
    mem_resp_ready = 1'b1;
    resp_v         = 1'b0;
    m0_resp_valid  = 1'b0;
    m1_resp_valid  = 1'b0;
    resp_rdata     = mem_resp_rdata;
    timeout_err    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          rdy0    = ~win_id;
          rdy1    = win_id;
          addr_d  = win_id ? m1_req_addr  : m0_req_addr;
          wdata_d = win_id ? m1_req_wdata : m0_req_wdata;
          wmask_d = win_id ? m1_req_wmask : m0_req_wmask;
          write_d = win_id ? m1_req_write : m0_req_write;
          grant_d = win_id;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_d = write_q ? ST_IDLE : ST_RESP;
          cnt_d   = 8'd0;
        end
      end
      ST_RESP: begin
        resp_v         = mem_resp_valid | forced;
        m0_resp_valid  = resp_v & ~grant_q;
        m1_resp_valid  = resp_v & grant_q;
        mem_resp_ready = up_ready;
        if (forced) begin
          resp_rdata  = 32'hDEADBEEF;
          timeout_err = (cnt_q == TO_LAST);
        end
        if (!mem_resp_valid && cnt_q != TO_MAX) cnt_d = cnt_q + 8'd1;
        if (resp_v && up_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Upstream ready is masked by reset so nothing is accepted while resetn is low.
  assign m0_req_ready  = rdy0 & resetn;
  assign m1_req_ready  = rdy1 & resetn;
  assign m0_resp_rdata = resp_rdata;
  assign m1_resp_rdata = resp_rdata;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wmask = wmask_q;
  assign mem_req_write = write_q;
  assign grant_id      = grant_q;
  assign busy          = (state_q != ST_IDLE);

  // State, latched request and timeout counter registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      write_q <= 1'b0;
      grant_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      write_q <= write_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized transaction-level bench for dmem_arbiter
module tb_dmem_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_req_valid, m0_req_ready, m0_req_write, m0_resp_valid, m0_resp_ready;
  logic [31:0] m0_req_addr, m0_req_wdata, m0_resp_rdata;
  logic [3:0]  m0_req_wmask;
  logic        m1_req_valid, m1_req_ready, m1_req_write, m1_resp_valid, m1_resp_ready;
  logic [31:0] m1_req_addr, m1_req_wdata, m1_resp_rdata;
  logic [3:0]  m1_req_wmask;
  logic        mem_req_valid, mem_req_ready, mem_req_write;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid, mem_resp_ready;
  logic [31:0] mem_resp_rdata;
  logic        grant_id, busy, timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Pending request per requester (the reference model of the two masters).
  logic        pv[2];
  logic [31:0] pa[2];
  logic [31:0] pd[2];
  logic [3:0]  pm[2];
  logic        pw[2];
  int          last_g;

  dmem_arbiter #(.RESP_TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_addr(m0_req_addr),
    .m0_req_wdata(m0_req_wdata), .m0_req_wmask(m0_req_wmask), .m0_req_write(m0_req_write),
    .m0_resp_valid(m0_resp_valid), .m0_resp_ready(m0_resp_ready), .m0_resp_rdata(m0_resp_rdata),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_addr(m1_req_addr),
    .m1_req_wdata(m1_req_wdata), .m1_req_wmask(m1_req_wmask), .m1_req_write(m1_req_write),
    .m1_resp_valid(m1_resp_valid), .m1_resp_ready(m1_resp_ready), .m1_resp_rdata(m1_resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask), .mem_req_write(mem_req_write),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_resp_rdata(mem_resp_rdata),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_reqs();
    m0_req_valid = pv[0]; m0_req_addr = pa[0]; m0_req_wdata = pd[0];
    m0_req_wmask = pm[0]; m0_req_write = pw[0];
    m1_req_valid = pv[1]; m1_req_addr = pa[1]; m1_req_wdata = pd[1];
    m1_req_wmask = pm[1]; m1_req_write = pw[1];
  endtask

  function automatic logic req_rdy(int n);
    return (n == 0) ? m0_req_ready : m1_req_ready;
  endfunction

  function automatic logic resp_vld(int n);
    return (n == 0) ? m0_resp_valid : m1_resp_valid;
  endfunction

  function automatic logic [31:0] resp_dat(int n);
    return (n == 0) ? m0_resp_rdata : m1_resp_rdata;
  endfunction

  initial begin
    int w, stall, k, c;
    logic stray, stray_next, mv, r, ev, eto, done;
    logic [31:0] ed, mdata;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wmask;
    logic        e_write;

    for (int n = 0; n < 2; n++) begin
      pv[n] = 1'b0; pa[n] = '0; pd[n] = '0; pm[n] = '0; pw[n] = 1'b0;
    end
    drive_reqs();
    m0_resp_ready = 1'b0; m1_resp_ready = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    stray_next = 1'b0;

    // Reset state, with a request pending that must not be accepted.
    resetn = 1'b0;
    m0_req_valid = 1'b1;
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_m0_req_ready", 32'(m0_req_ready), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_mem_resp_ready", 32'(mem_resp_ready), 32'd1);
    @(posedge clk); #1;
    resetn = 1'b1;
    drive_reqs();
    last_g = 1;

    for (int t = 0; t < 80; t++) begin
      // New requests appear; an unserved one stays pending.
      for (int n = 0; n < 2; n++) begin
        if (!pv[n] && $urandom_range(0, 2) != 0) begin
          pv[n] = 1'b1; pa[n] = $urandom; pd[n] = $urandom;
          pm[n] = 4'($urandom); pw[n] = 1'($urandom_range(0, 1));
        end
      end
      if (!pv[0] && !pv[1]) begin
        w = $urandom_range(0, 1);
        pv[w] = 1'b1; pa[w] = $urandom; pd[w] = $urandom;
        pm[w] = 4'($urandom); pw[w] = 1'($urandom_range(0, 1));
      end
      drive_reqs();
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
      m0_resp_ready = 1'b0; m1_resp_ready = 1'b0;

`ifdef DMEM_ARBITER_RR_EN
      if (pv[0] && pv[1]) w = 1 - last_g;
      else w = pv[0] ? 0 : 1;
`else
      w = pv[0] ? 0 : 1;
`endif

      // IDLE: winner sees ready in the same cycle, loser does not.
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_mem_req_valid", 32'(mem_req_valid), 32'd0);
      check("idle_rdy_win", 32'(req_rdy(w)), 32'd1);
      check("idle_rdy_lose", 32'(req_rdy(1 - w)), 32'd0);
      check("idle_resp_valid", 32'({m0_resp_valid, m1_resp_valid}), 32'd0);
      check("idle_mem_resp_ready", 32'(mem_resp_ready), 32'd1);
      @(posedge clk); #1;

      last_g  = w;
      e_addr  = pa[w]; e_wdata = pd[w]; e_wmask = pm[w]; e_write = pw[w];
      pv[w]   = 1'b0;
      drive_reqs();

      // REQ: forward the latched fields, ignore pending requesters, drop stray responses.
      stall = $urandom_range(0, 2);
      stray = stray_next || ($urandom_range(0, 3) == 0);
      for (int s = 0; s <= stall; s++) begin
        mem_req_ready  = (s == stall);
        mem_resp_valid = (s == 0) && stray;
        mem_resp_rdata = $urandom;
        @(negedge clk);
        check("req_mem_req_valid", 32'(mem_req_valid), 32'd1);
        check("req_addr", mem_req_addr, e_addr);
        check("req_wdata", mem_req_wdata, e_wdata);
        check("req_wmask", 32'(mem_req_wmask), 32'(e_wmask));
        check("req_write", 32'(mem_req_write), 32'(e_write));
        check("req_grant_id", 32'(grant_id), 32'(w));
        check("req_busy", 32'(busy), 32'd1);
        check("req_rdy", 32'({m0_req_ready, m1_req_ready}), 32'd0);
        check("req_mem_resp_ready", 32'(mem_resp_ready), 32'd1);
        check("req_resp_valid", 32'({m0_resp_valid, m1_resp_valid}), 32'd0);
        @(posedge clk); #1;
      end
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
      stray_next = 1'b0;

      if (!e_write) begin
        // RESP: memory answers on RESP cycle k, or the timeout completes at cycle TO.
        k = $urandom_range(1, 7);
        mdata = $urandom;
        c = 0;
        done = 1'b0;
        while (!done) begin
          c++;
          mv = (c >= k);
          mem_resp_valid = mv;
          mem_resp_rdata = mv ? mdata : $urandom;
          r = ($urandom_range(0, 3) != 0);
          if (w == 0) begin m0_resp_ready = r; m1_resp_ready = 1'($urandom_range(0, 1)); end
          else        begin m1_resp_ready = r; m0_resp_ready = 1'($urandom_range(0, 1)); end
          if (mv)           begin ev = 1'b1; ed = mdata;        eto = 1'b0;      end
          else if (c >= TO) begin ev = 1'b1; ed = 32'hDEADBEEF; eto = (c == TO); end
          else              begin ev = 1'b0; ed = '0;           eto = 1'b0;      end
          @(negedge clk);
          check("resp_valid_win", 32'(resp_vld(w)), 32'(ev));
          check("resp_valid_lose", 32'(resp_vld(1 - w)), 32'd0);
          if (ev) check("resp_rdata", resp_dat(w), ed);
          check("resp_timeout_err", 32'(timeout_err), 32'(eto));
          check("resp_mem_resp_ready", 32'(mem_resp_ready), 32'(r));
          check("resp_busy", 32'(busy), 32'd1);
          check("resp_mem_req_valid", 32'(mem_req_valid), 32'd0);
          check("resp_grant_id", 32'(grant_id), 32'(w));
          check("resp_rdy", 32'({m0_req_ready, m1_req_ready}), 32'd0);
          @(posedge clk); #1;
          if ((ev && r) || c >= 200) done = 1'b1;
        end
        mem_resp_valid = 1'b0;
        m0_resp_ready = 1'b0; m1_resp_ready = 1'b0;
        // A memory that never answered delivers late into the next transaction.
        stray_next = (k > c);
      end
    end

    // Reset in the middle of a load.
    for (int n = 0; n < 2; n++) pv[n] = 1'b0;
    drive_reqs();
    m0_req_valid = 1'b1; m0_req_write = 1'b0; m0_req_addr = 32'h200;
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    m0_req_valid = 1'b0;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hCAFEF00D; m0_resp_ready = 1'b0;
    #1;
    check("mid_resp_valid", 32'(m0_resp_valid), 32'd1);
    check("mid_resp_rdata", m0_resp_rdata, 32'hCAFEF00D);
    m0_req_valid = 1'b1; m1_req_valid = 1'b1; m1_req_write = 1'b0;
    resetn = 1'b0;
    #1;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    check("mrst_resp_valid", 32'({m0_resp_valid, m1_resp_valid}), 32'd0);
    check("mrst_rdy", 32'({m0_req_ready, m1_req_ready}), 32'd0);
    check("mrst_timeout_err", 32'(timeout_err), 32'd0);
    check("mrst_grant_id", 32'(grant_id), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    #1;
    check("post_rst_rdy0", 32'(m0_req_ready), 32'd1);
    check("post_rst_rdy1", 32'(m1_req_ready), 32'd0);
    check("post_rst_resp_valid", 32'({m0_resp_valid, m1_resp_valid}), 32'd0);
    check("post_rst_mem_resp_ready", 32'(mem_resp_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
